// File: rtl/fsm_pattern_sequencer.sv
// Drives an LEN-bit pattern MSB-first into a downstream Moore FSM and records its y response per bit.
// Optional abort input enabled by defining SEQ_ABORT_EN.
module fsm_pattern_sequencer #(
   parameter int LEN = 8,
   parameter int CW  = $clog2(LEN+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [LEN-1:0] pattern,
`ifdef SEQ_ABORT_EN
   input  logic           abort,
`endif
   output logic           w,
   output logic           fsm_rst,
   input  logic           y,
   output logic           busy,
   output logic           done,
   output logic [CW-1:0]  hit_count,
   output logic [LEN-1:0] hit_map
);

   localparam int IW = $clog2(LEN);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

   state_t         r_state;
   logic [LEN-1:0] r_pat;
   logic [IW-1:0]  r_idx;
   logic [IW-1:0]  r_smp_idx;
   logic           r_smp_vld;
   logic           r_w;
   logic           r_fsm_rst;
   logic           r_busy;
   logic           r_done;
   logic [CW-1:0]  r_hit_count;
   logic [LEN-1:0] r_hit_map;
   logic [IW-1:0]  w_idx_dn;

   assign w_idx_dn = r_idx - IW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_pat       <= '0;
         r_idx       <= '0;
         r_smp_idx   <= '0;
         r_smp_vld   <= 1'b0;
         r_w         <= 1'b0;
         r_fsm_rst   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_hit_count <= '0;
         r_hit_map   <= '0;
      end else begin
         r_done    <= 1'b0;
         r_fsm_rst <= 1'b0;
         r_smp_vld <= 1'b0;
         // y in this cycle reflects the bit driven in the previous SHIFT cycle
         if (r_smp_vld && y) begin
            r_hit_map[r_smp_idx] <= 1'b1;
            r_hit_count          <= r_hit_count + CW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pat       <= pattern;
                  r_hit_count <= '0;
                  r_hit_map   <= '0;
                  r_fsm_rst   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_w         <= 1'b0;
                  r_state     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_idx   <= IW'(LEN-1);
               r_w     <= r_pat[LEN-1];
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_smp_vld <= 1'b1;
               r_smp_idx <= r_idx;
               if (r_idx == '0) begin
                  r_w     <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  r_idx <= w_idx_dn;
                  r_w   <= r_pat[w_idx_dn];
               end
            end
            S_DRAIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
`ifdef SEQ_ABORT_EN
         // the sample taken in the abort cycle is still kept
         if (abort && r_busy) begin
            r_state   <= S_IDLE;
            r_w       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fsm_rst <= 1'b0;
            r_smp_vld <= 1'b0;
         end
`endif
      end
   end

   assign w         = r_w;
   assign fsm_rst   = r_fsm_rst;
   assign busy      = r_busy;
   assign done      = r_done;
   assign hit_count = r_hit_count;
   assign hit_map   = r_hit_map;

endmodule

// File: tb/tb_fsm_pattern_sequencer.sv
// Randomized bench for fsm_pattern_sequencer with a phase-counter reference model and a 3-state downstream FSM.
module tb_fsm_pattern_sequencer;
   localparam int LEN = 8;
   localparam int CW  = $clog2(LEN+1);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [LEN-1:0] pattern = '0;
   logic           y;
   logic           w, fsm_rst, busy, done;
   logic [CW-1:0]  hit_count;
   logic [LEN-1:0] hit_map;
`ifdef SEQ_ABORT_EN
   logic           abort = 1'b0;
`endif

   fsm_pattern_sequencer #(.LEN(LEN)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern),
`ifdef SEQ_ABORT_EN
      .abort(abort),
`endif
      .w(w), .fsm_rst(fsm_rst), .y(y), .busy(busy), .done(done),
      .hit_count(hit_count), .hit_map(hit_map));

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // downstream Moore FSM: A=0 B=1 C=2, y=1 in C; optional random y instead
   logic [1:0] ds = 2'd0;
   logic       rnd_y = 1'b0, ry = 1'b0;
   always @(posedge clk) begin
      if (fsm_rst) ds <= 2'd0;
      else case (ds)
         2'd0:    ds <= w ? 2'd1 : 2'd2;
         2'd1:    ds <= w ? 2'd0 : 2'd2;
         default: ds <= w ? 2'd1 : 2'd2;
      endcase
      ry <= 1'($urandom_range(0, 1));
   end
   assign y = rnd_y ? ry : (ds == 2'd2);

   function automatic logic [LEN-1:0] golden(input logic [LEN-1:0] p);
      int st = 0;
      logic [LEN-1:0] m = '0;
      for (int i = LEN-1; i >= 0; i--) begin
         if (st == 1) st = p[i] ? 0 : 2;
         else         st = p[i] ? 1 : 2;
         m[i] = (st == 2);
      end
      return m;
   endfunction

   // model: t = cycles since acceptance (0 = idle); bit k driven at t=LEN+1-k, sampled at t=LEN+2-k
   int             t = 0, mcnt = 0;
   logic [LEN-1:0] mpat = '0, mmap = '0;
   logic           ab;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         t = 0; mmap = '0; mcnt = 0;
      end else begin
         ab = 1'b0;
`ifdef SEQ_ABORT_EN
         ab = abort;
`endif
         if (t >= 3 && t <= LEN+2 && y) begin
            mmap[LEN+2-t] = 1'b1;
            mcnt++;
         end
         if (ab && t >= 1 && t <= LEN+2) t = 0;
         else if (t == 0) begin
            if (start) begin t = 1; mpat = pattern; mmap = '0; mcnt = 0; end
         end
         else if (t == LEN+3) t = 0;
         else t++;
      end
   end

   always @(negedge clk) begin : cmp
      logic ew;
      ew = (t >= 2 && t <= LEN+1) ? mpat[LEN+1-t] : 1'b0;
      chk("busy",      32'(busy),      32'(t >= 1 && t <= LEN+2));
      chk("fsm_rst",   32'(fsm_rst),   32'(t == 1));
      chk("w",         32'(w),         32'(ew));
      chk("done",      32'(done),      32'(t == LEN+3));
      chk("hit_count", 32'(hit_count), 32'(mcnt));
      chk("hit_map",   32'(hit_map),   32'(mmap));
   end

   task automatic run(input logic [LEN-1:0] p);
      int c0, lat, nr;
      logic [LEN-1:0] ws;
      @(negedge clk); start = 1'b1; pattern = p; c0 = cyc;
      @(negedge clk); start = 1'b0; pattern = LEN'($urandom);
      lat = -1; nr = 0; ws = '0;
      for (int k = 0; k < 40; k++) begin
         if (fsm_rst) nr++;
         if (cyc-c0 >= 2 && cyc-c0 <= LEN+1) ws[LEN+1-(cyc-c0)] = w;
         if (done) begin lat = cyc - c0; break; end
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'(LEN+3));
      chk("fsm_rst_pulses", 32'(nr), 32'd1);
      chk("w_sequence", 32'(ws), 32'(p));
   endtask

   initial begin
      logic [LEN-1:0] p;
      int dq[$];
      #2 rst = 1'b0;
      #1;
      chk("rst_w", 32'(w), 0);       chk("rst_fsm_rst", 32'(fsm_rst), 0);
      chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
      chk("rst_cnt", 32'(hit_count), 0); chk("rst_map", 32'(hit_map), 0);
      @(negedge clk); @(negedge clk); rst = 1'b1;

      run(8'hB2);
      chk("B2_cnt", 32'(hit_count), 32'd4);  chk("B2_map", 32'(hit_map), 32'h4D);
      run(8'h00);
      chk("00_cnt", 32'(hit_count), 32'd8);  chk("00_map", 32'(hit_map), 32'hFF);
      run(8'hFF);
      chk("FF_cnt", 32'(hit_count), 32'd0);  chk("FF_map", 32'(hit_map), 32'h00);
      repeat (3) @(negedge clk);
      chk("hold_map", 32'(hit_map), 32'h00);

      for (int r = 0; r < 20; r++) begin
         p = LEN'($urandom);
         run(p);
         chk("rnd_map", 32'(hit_map), 32'(golden(p)));
         chk("rnd_cnt", 32'(hit_count), 32'($countones(golden(p))));
      end

      // start held high: back-to-back runs, one per IDLE entry
      @(negedge clk); start = 1'b1; pattern = 8'hB2;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) begin
            dq.push_back(cyc);
            chk("held_cnt", 32'(hit_count), 32'd4);
            chk("held_map", 32'(hit_map), 32'h4D);
         end
      end
      start = 1'b0;
      chk("held_runs", 32'(dq.size()), 32'd3);
      for (int i = 1; i < dq.size(); i++) chk("held_spacing", 32'(dq[i]-dq[i-1]), 32'd12);
      repeat (15) @(negedge clk);

      // reset during SHIFT cycle 5
      @(negedge clk); start = 1'b1; pattern = 8'h0F;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_w", 32'(w), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_w", 32'(w), 0);        chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_cnt", 32'(hit_count), 0); chk("mid_rst_map", 32'(hit_map), 0);
      chk("mid_rst_done", 32'(done), 0);  chk("mid_rst_fsm_rst", 32'(fsm_rst), 0);
      @(negedge clk); @(negedge clk); rst = 1'b1;
      run(8'h00);
      chk("post_rst_cnt", 32'(hit_count), 32'd8);
      chk("post_rst_map", 32'(hit_map), 32'hFF);

`ifdef SEQ_ABORT_EN
      @(negedge clk); @(negedge clk); start = 1'b1; pattern = 8'h00;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cnt", 32'(hit_count), 32'd3);
      chk("abort_map", 32'(hit_map), 32'hE0);
      repeat (15) @(negedge clk);
      chk("abort_keep_map", 32'(hit_map), 32'hE0);
`endif

      // free-running random traffic, checked cycle by cycle
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (k % 100 == 0) rnd_y = 1'($urandom_range(0, 1));
         start   = ($urandom_range(0, 3) == 0);
         pattern = LEN'($urandom);
`ifdef SEQ_ABORT_EN
         abort   = ($urandom_range(0, 15) == 0);
`endif
      end
      start = 1'b0; rnd_y = 1'b0;
`ifdef SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (15) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
